bsg_axil_mcl_ingress_slice: RTL and testbench

Registered AXI-Lite pipeline slice with outstanding-transaction limiting. It sits directly upstream of the AXIL-to-manycore-link bridge, between the host shell's AXI-Lite master and the bridge's slave port. It breaks every combinational valid/ready/data path on the five channels so the bridge can be placed far from the shell. It also bounds in-flight writes and reads, and reports when the port is idle for host-side reset or drain sequencing.

---
 rtl/bsg_axi_bus_pkg.sv | 50 +++++
 rtl/bsg_axil_skid_slice.sv | 62 ++++++
 rtl/bsg_axil_mcl_ingress_slice.sv | 181 ++++++++++++++++++
 tb/tb_bsg_axil_mcl_ingress_slice.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsg_axi_bus_pkg.sv
// Shared AXI-Lite bus definitions for the manycore-link ingress path:
// packed MOSI/MISO structs, per-channel payload widths and slice-mask bit positions.
package bsg_axi_bus_pkg;

    localparam int axil_addr_width_gp = 32;
    localparam int axil_data_width_gp = 32;

    // Payload widths of the registered channels (valid/ready excluded)
    localparam int axil_aw_width_gp = axil_addr_width_gp + 3;
    localparam int axil_w_width_gp  = axil_data_width_gp + axil_data_width_gp/8;
    localparam int axil_b_width_gp  = 2;
    localparam int axil_ar_width_gp = axil_addr_width_gp + 3;
    localparam int axil_r_width_gp  = axil_data_width_gp + 2;

    // Bit positions inside slice_mask_p, order {R,AR,B,W,AW}
    localparam int slice_aw_idx_gp = 0;
    localparam int slice_w_idx_gp  = 1;
    localparam int slice_b_idx_gp  = 2;
    localparam int slice_ar_idx_gp = 3;
    localparam int slice_r_idx_gp  = 4;

    typedef struct packed {
        logic [axil_addr_width_gp-1:0]   awaddr;
        logic [2:0]                      awprot;
        logic                            awvalid;
        logic [axil_data_width_gp-1:0]   wdata;
        logic [axil_data_width_gp/8-1:0] wstrb;
        logic                            wvalid;
        logic                            bready;
        logic [axil_addr_width_gp-1:0]   araddr;
        logic [2:0]                      arprot;
        logic                            arvalid;
        logic                            rready;
    } bsg_axil_mosi_s;

    typedef struct packed {
        logic                            awready;
        logic                            wready;
        logic [1:0]                      bresp;
        logic                            bvalid;
        logic                            arready;
        logic [axil_data_width_gp-1:0]   rdata;
        logic [1:0]                      rresp;
        logic                            rvalid;
    } bsg_axil_miso_s;

    localparam int bsg_axil_mosi_bus_width_gp = $bits(bsg_axil_mosi_s);
    localparam int bsg_axil_miso_bus_width_gp = $bits(bsg_axil_miso_s);

endpackage

// File: rtl/bsg_axil_skid_slice.sv
// Two-entry registered slice: valid, ready and data toward both sides all come from flops.
// Handshake: a beat moves on a side exactly when that side's valid and ready are both high.
module bsg_axil_skid_slice #(
    parameter int width_p = 8
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               v_i,
    input  logic [width_p-1:0] data_i,
    output logic               ready_o,
    output logic               v_o,
    output logic [width_p-1:0] data_o,
    input  logic               ready_i,
    output logic               empty_next_o
);

    logic [1:0]         count_q, count_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic               ready_q;
    logic [width_p-1:0] mem_q [2];
    logic               enq, deq;

    assign enq = v_i & ready_q;
    assign deq = (count_q != 2'd0) & ready_i;

    always_comb begin
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q ^ deq;
        wr_ptr_d = wr_ptr_q ^ enq;
        case ({enq, deq})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            count_q  <= 2'd0;
            rd_ptr_q <= 1'b0;
            wr_ptr_q <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            ready_q  <= (count_d != 2'd2);
        end
    end

    // Storage needs no reset; count_q alone decides what is valid
    always_ff @(posedge clk_i) begin
        if (enq) mem_q[wr_ptr_q] <= data_i;
    end

    assign ready_o      = ready_q;
    assign v_o          = (count_q != 2'd0);
    assign data_o       = mem_q[rd_ptr_q];
    assign empty_next_o = (count_d == 2'd0);

endmodule

// File: rtl/bsg_axil_mcl_ingress_slice.sv
// AXI-Lite pipeline slice in front of the manycore-link bridge with per-direction
// outstanding-transaction limits and a registered idle indication.
module bsg_axil_mcl_ingress_slice
    import bsg_axi_bus_pkg::*;
#(
    parameter logic [4:0] slice_mask_p           = 5'b11111,
    parameter int         max_wr_outstanding_p   = 4,
    parameter int         max_rd_outstanding_p   = 4,
    parameter int         axil_mosi_bus_width_lp = bsg_axil_mosi_bus_width_gp,
    parameter int         axil_miso_bus_width_lp = bsg_axil_miso_bus_width_gp
) (
    input  logic                              clk_i,
    input  logic                              reset_i,
    input  logic [axil_mosi_bus_width_lp-1:0] s_axil_bus_i,
    output logic [axil_miso_bus_width_lp-1:0] s_axil_bus_o,
    output logic [axil_mosi_bus_width_lp-1:0] m_axil_bus_o,
    input  logic [axil_miso_bus_width_lp-1:0] m_axil_bus_i,
    output logic [7:0]                        wr_outstanding_o,
    output logic [7:0]                        rd_outstanding_o,
    output logic                              idle_o
);

    localparam logic [7:0] max_wr_lp = 8'(max_wr_outstanding_p);
    localparam logic [7:0] max_rd_lp = 8'(max_rd_outstanding_p);

    bsg_axil_mosi_s s_mosi, m_mosi;
    bsg_axil_miso_s s_miso, m_miso;

    assign s_mosi       = s_axil_bus_i;
    assign m_miso       = m_axil_bus_i;
    assign s_axil_bus_o = s_miso;
    assign m_axil_bus_o = m_mosi;

    logic [7:0] wr_cnt_q, wr_cnt_d, rd_cnt_q, rd_cnt_d;
    logic       idle_q, idle_d;
    logic       wr_room, rd_room, aw_hs, b_hs, ar_hs, r_hs;

    logic                        aw_s_v, aw_s_ready, aw_m_v, aw_m_ready, aw_empty;
    logic [axil_aw_width_gp-1:0] aw_s_data, aw_m_data;
    logic                        w_s_v, w_s_ready, w_m_v, w_m_ready, w_empty;
    logic [axil_w_width_gp-1:0]  w_s_data, w_m_data;
    logic                        b_s_v, b_s_ready, b_m_v, b_m_ready, b_empty;
    logic [axil_b_width_gp-1:0]  b_s_data, b_m_data;
    logic                        ar_s_v, ar_s_ready, ar_m_v, ar_m_ready, ar_empty;
    logic [axil_ar_width_gp-1:0] ar_s_data, ar_m_data;
    logic                        r_s_v, r_s_ready, r_m_v, r_m_ready, r_empty;
    logic [axil_r_width_gp-1:0]  r_s_data, r_m_data;

    // Gating looks only at the registered count, so a same-cycle B/R never frees a slot early
    assign wr_room = (wr_cnt_q < max_wr_lp);
    assign rd_room = (rd_cnt_q < max_rd_lp);

    assign aw_s_v    = s_mosi.awvalid & wr_room;
    assign aw_s_data = {s_mosi.awaddr, s_mosi.awprot};
    assign aw_m_ready = m_miso.awready;
    assign w_s_v     = s_mosi.wvalid;
    assign w_s_data  = {s_mosi.wdata, s_mosi.wstrb};
    assign w_m_ready = m_miso.wready;
    assign b_s_v     = m_miso.bvalid;
    assign b_s_data  = m_miso.bresp;
    assign b_m_ready = s_mosi.bready;
    assign ar_s_v    = s_mosi.arvalid & rd_room;
    assign ar_s_data = {s_mosi.araddr, s_mosi.arprot};
    assign ar_m_ready = m_miso.arready;
    assign r_s_v     = m_miso.rvalid;
    assign r_s_data  = {m_miso.rdata, m_miso.rresp};
    assign r_m_ready = s_mosi.rready;

    if (slice_mask_p[slice_aw_idx_gp]) begin : g_aw_slice
        bsg_axil_skid_slice #(.width_p(axil_aw_width_gp)) u_slice (
            .clk_i(clk_i), .reset_i(reset_i),
            .v_i(aw_s_v), .data_i(aw_s_data), .ready_o(aw_s_ready),
            .v_o(aw_m_v), .data_o(aw_m_data), .ready_i(aw_m_ready), .empty_next_o(aw_empty));
    end else begin : g_aw_wire
        assign aw_m_v = aw_s_v; assign aw_m_data = aw_s_data;
        assign aw_s_ready = aw_m_ready; assign aw_empty = 1'b1;
    end

    if (slice_mask_p[slice_w_idx_gp]) begin : g_w_slice
        bsg_axil_skid_slice #(.width_p(axil_w_width_gp)) u_slice (
            .clk_i(clk_i), .reset_i(reset_i),
            .v_i(w_s_v), .data_i(w_s_data), .ready_o(w_s_ready),
            .v_o(w_m_v), .data_o(w_m_data), .ready_i(w_m_ready), .empty_next_o(w_empty));
    end else begin : g_w_wire
        assign w_m_v = w_s_v; assign w_m_data = w_s_data;
        assign w_s_ready = w_m_ready; assign w_empty = 1'b1;
    end

    if (slice_mask_p[slice_b_idx_gp]) begin : g_b_slice
        bsg_axil_skid_slice #(.width_p(axil_b_width_gp)) u_slice (
            .clk_i(clk_i), .reset_i(reset_i),
            .v_i(b_s_v), .data_i(b_s_data), .ready_o(b_s_ready),
            .v_o(b_m_v), .data_o(b_m_data), .ready_i(b_m_ready), .empty_next_o(b_empty));
    end else begin : g_b_wire
        assign b_m_v = b_s_v; assign b_m_data = b_s_data;
        assign b_s_ready = b_m_ready; assign b_empty = 1'b1;
    end

    if (slice_mask_p[slice_ar_idx_gp]) begin : g_ar_slice
        bsg_axil_skid_slice #(.width_p(axil_ar_width_gp)) u_slice (
            .clk_i(clk_i), .reset_i(reset_i),
            .v_i(ar_s_v), .data_i(ar_s_data), .ready_o(ar_s_ready),
            .v_o(ar_m_v), .data_o(ar_m_data), .ready_i(ar_m_ready), .empty_next_o(ar_empty));
    end else begin : g_ar_wire
        assign ar_m_v = ar_s_v; assign ar_m_data = ar_s_data;
        assign ar_s_ready = ar_m_ready; assign ar_empty = 1'b1;
    end

    if (slice_mask_p[slice_r_idx_gp]) begin : g_r_slice
        bsg_axil_skid_slice #(.width_p(axil_r_width_gp)) u_slice (
            .clk_i(clk_i), .reset_i(reset_i),
            .v_i(r_s_v), .data_i(r_s_data), .ready_o(r_s_ready),
            .v_o(r_m_v), .data_o(r_m_data), .ready_i(r_m_ready), .empty_next_o(r_empty));
    end else begin : g_r_wire
        assign r_m_v = r_s_v; assign r_m_data = r_s_data;
        assign r_s_ready = r_m_ready; assign r_empty = 1'b1;
    end

    always_comb begin
        m_mosi = '0;
        s_miso = '0;
        {m_mosi.awaddr, m_mosi.awprot} = aw_m_data;
        m_mosi.awvalid                 = aw_m_v;
        {m_mosi.wdata, m_mosi.wstrb}   = w_m_data;
        m_mosi.wvalid                  = w_m_v;
        m_mosi.bready                  = b_s_ready;
        {m_mosi.araddr, m_mosi.arprot} = ar_m_data;
        m_mosi.arvalid                 = ar_m_v;
        m_mosi.rready                  = r_s_ready;
        s_miso.awready                 = aw_s_ready & wr_room;
        s_miso.wready                  = w_s_ready;
        s_miso.bresp                   = b_m_data;
        s_miso.bvalid                  = b_m_v;
        s_miso.arready                 = ar_s_ready & rd_room;
        {s_miso.rdata, s_miso.rresp}   = r_m_data;
        s_miso.rvalid                  = r_m_v;
    end

    assign aw_hs = aw_s_v & aw_s_ready;
    assign b_hs  = b_m_v & s_mosi.bready;
    assign ar_hs = ar_s_v & ar_s_ready;
    assign r_hs  = r_m_v & s_mosi.rready;

    // A B/R with nothing outstanding leaves the count at zero instead of wrapping
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        rd_cnt_d = rd_cnt_q;
        if (aw_hs && !b_hs)                        wr_cnt_d = wr_cnt_q + 8'd1;
        else if (b_hs && !aw_hs && wr_cnt_q != '0) wr_cnt_d = wr_cnt_q - 8'd1;
        if (ar_hs && !r_hs)                        rd_cnt_d = rd_cnt_q + 8'd1;
        else if (r_hs && !ar_hs && rd_cnt_q != '0) rd_cnt_d = rd_cnt_q - 8'd1;
        idle_d = aw_empty & w_empty & b_empty & ar_empty & r_empty
               & (wr_cnt_d == '0) & (rd_cnt_d == '0);
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_cnt_q <= '0;
            rd_cnt_q <= '0;
            idle_q   <= 1'b1;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            idle_q   <= idle_d;
        end
    end

    assign wr_outstanding_o = wr_cnt_q;
    assign rd_outstanding_o = rd_cnt_q;
    assign idle_o           = idle_q;

`ifndef SYNTHESIS
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            assert (!(b_hs && wr_cnt_q == '0)) else $error("write counter underflow: B with no write outstanding");
            assert (!(r_hs && rd_cnt_q == '0)) else $error("read counter underflow: R with no read outstanding");
        end
    end
`endif

endmodule

// File: tb/tb_bsg_axil_mcl_ingress_slice.sv
// Directed bench for the AXI-Lite ingress slice: reset, single write, AR streaming,
// read throttling, W backpressure, write-limit edge and reset with read data buffered.
module tb_bsg_axil_mcl_ingress_slice;
    import bsg_axi_bus_pkg::*;

    logic           clk = 1'b0;
    logic           reset;
    bsg_axil_mosi_s s_mosi, m_mosi;
    bsg_axil_miso_s s_miso, m_miso;
    logic [7:0]     wr_out, rd_out;
    logic           idle;

    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_q[$];
    logic [31:0] exp_r_q[$];

    bsg_axil_mcl_ingress_slice #(
        .slice_mask_p(5'b11111),
        .max_wr_outstanding_p(2),
        .max_rd_outstanding_p(4)
    ) dut (
        .clk_i(clk),
        .reset_i(reset),
        .s_axil_bus_i(s_mosi),
        .s_axil_bus_o(s_miso),
        .m_axil_bus_o(m_mosi),
        .m_axil_bus_i(m_miso),
        .wr_outstanding_o(wr_out),
        .rd_outstanding_o(rd_out),
        .idle_o(idle)
    );

    // clock / reset
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pop_exp(inout logic [31:0] q[$]);
        if (q.size() == 0) return 32'hbad0_bad0;
        return q.pop_front();
    endfunction

    initial begin
        int          first_c, last_c, n_m, n_r, max_rd, idx, n_w;
        logic [31:0] wd [5];
        wd = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003, 32'h4444_0004, 32'h5555_0005};

        // ---------------- reset ----------------
        reset  = 1'b1;
        s_mosi = '0;
        m_miso = '0;
        repeat (3) tick();
        settle();
        check("rst_awready", s_miso.awready, 0);
        check("rst_wready",  s_miso.wready, 0);
        check("rst_arready", s_miso.arready, 0);
        check("rst_bready",  m_mosi.bready, 0);
        check("rst_rready",  m_mosi.rready, 0);
        check("rst_valids",  {m_mosi.awvalid, m_mosi.wvalid, m_mosi.arvalid, s_miso.bvalid, s_miso.rvalid}, 0);
        check("rst_counts",  {wr_out, rd_out}, 0);
        check("rst_idle",    idle, 1);
        reset = 1'b0;
        settle();
        check("rel_pre_rdy", s_miso.awready, 0);
        tick();
        settle();
        check("rel_readies", {s_miso.awready, s_miso.wready, s_miso.arready, m_mosi.bready, m_mosi.rready}, 5'b11111);
        check("rel_idle", idle, 1);

        // ---------------- single write ----------------
        tick();
        s_mosi.awvalid = 1'b1; s_mosi.awaddr = 32'h0000_1000; s_mosi.awprot = 3'd0;
        s_mosi.wvalid  = 1'b1; s_mosi.wdata  = 32'hDEAD_BEEF; s_mosi.wstrb  = 4'hf;
        s_mosi.bready  = 1'b1;
        settle();
        check("wr_c0_awready", s_miso.awready, 1);
        check("wr_c0_m_awv", m_mosi.awvalid, 0);
        tick();
        s_mosi.awvalid = 1'b0; s_mosi.wvalid = 1'b0;
        m_miso.awready = 1'b1; m_miso.wready = 1'b1;
        settle();
        check("wr_c1_m_awv", m_mosi.awvalid, 1);
        check("wr_c1_awaddr", m_mosi.awaddr, 32'h0000_1000);
        check("wr_c1_m_wv", m_mosi.wvalid, 1);
        check("wr_c1_wdata", m_mosi.wdata, 32'hDEAD_BEEF);
        check("wr_c1_out", wr_out, 1);
        check("wr_c1_idle", idle, 0);
        tick();
        m_miso.awready = 1'b0; m_miso.wready = 1'b0;
        settle();
        check("wr_c2_m_awv", m_mosi.awvalid, 0);
        tick();
        m_miso.bvalid = 1'b1; m_miso.bresp = 2'b00;
        settle();
        check("wr_c3_bready", m_mosi.bready, 1);
        check("wr_c3_s_bv", s_miso.bvalid, 0);
        tick();
        m_miso.bvalid = 1'b0;
        settle();
        check("wr_c4_s_bv", s_miso.bvalid, 1);
        check("wr_c4_bresp", s_miso.bresp, 0);
        check("wr_c4_out", wr_out, 1);
        tick();
        settle();
        check("wr_c5_s_bv", s_miso.bvalid, 0);
        check("wr_c5_out", wr_out, 0);
        check("wr_c5_idle", idle, 1);

        // ---------------- write limit edge (limit 2) ----------------
        tick();
        m_miso.awready = 1'b1; s_mosi.bready = 1'b0;
        s_mosi.awvalid = 1'b1; s_mosi.awaddr = 32'h0000_2000;
        settle();
        check("lim_aw1_rdy", s_miso.awready, 1);
        tick();
        s_mosi.awaddr = 32'h0000_2004;
        settle();
        check("lim_aw2_rdy", s_miso.awready, 1);
        check("lim_m_aw1", m_mosi.awaddr, 32'h0000_2000);
        tick();
        s_mosi.awaddr = 32'h0000_2008;
        m_miso.bvalid = 1'b1; m_miso.bresp = 2'b00;
        settle();
        check("lim_aw3_stall", s_miso.awready, 0);
        check("lim_out2", wr_out, 2);
        tick();
        m_miso.bvalid = 1'b0;
        settle();
        check("lim_stall_b_wait", s_miso.awready, 0);
        check("lim_s_bv", s_miso.bvalid, 1);
        tick();
        s_mosi.bready = 1'b1;
        settle();
        check("lim_same_cycle", s_miso.awready, 0);
        tick();
        s_mosi.bready = 1'b0;
        settle();
        check("lim_next_cycle", s_miso.awready, 1);
        check("lim_out1", wr_out, 1);
        tick();
        s_mosi.awvalid = 1'b0;
        settle();
        check("lim_m_aw3_v", m_mosi.awvalid, 1);
        check("lim_m_aw3", m_mosi.awaddr, 32'h0000_2008);
        check("lim_out_back2", wr_out, 2);
        tick();
        m_miso.awready = 1'b0;
        m_miso.bvalid = 1'b1; m_miso.bresp = 2'b00; s_mosi.bready = 1'b1;
        tick();
        tick();
        m_miso.bvalid = 1'b0;
        repeat (3) tick();
        settle();
        check("lim_drain_out", wr_out, 0);
        check("lim_drain_idle", idle, 1);

        // ---------------- AR streaming ----------------
        m_miso.arready = 1'b1; s_mosi.rready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            exp_q.push_back(32'h0000_0100 + 32'(i * 4));
            exp_r_q.push_back(32'h0000_0100 + 32'(i * 4));
        end
        first_c = -1; last_c = -1; n_m = 0; n_r = 0; max_rd = 0;
        for (int c = 0; c < 24; c++) begin
            tick();
            m_miso.rvalid = m_mosi.arvalid;
            m_miso.rdata  = m_mosi.araddr;
            m_miso.rresp  = 2'b00;
            if (c < 16) begin
                s_mosi.arvalid = 1'b1;
                s_mosi.araddr  = 32'h0000_0100 + 32'(c * 4);
            end else begin
                s_mosi.arvalid = 1'b0;
            end
            settle();
            if (c < 16) check("str_arready", s_miso.arready, 1);
            if (int'(rd_out) > max_rd) max_rd = int'(rd_out);
            if (m_mosi.arvalid && m_miso.arready) begin
                check("str_m_araddr", m_mosi.araddr, pop_exp(exp_q));
                if (first_c < 0) first_c = c;
                last_c = c;
                n_m++;
            end
            if (s_miso.rvalid && s_mosi.rready) begin
                check("str_s_rdata", s_miso.rdata, pop_exp(exp_r_q));
                n_r++;
            end
        end
        check("str_m_count", n_m, 16);
        check("str_m_span", last_c - first_c, 15);
        check("str_max_rd", (max_rd <= 4), 1);
        check("str_r_count", n_r, 16);
        check("str_rd_out", rd_out, 0);

        // ---------------- read throttle (limit 4) ----------------
        m_miso.rvalid = 1'b0;
        for (int c = 0; c < 5; c++) begin
            tick();
            s_mosi.arvalid = 1'b1;
            s_mosi.araddr  = 32'h0000_0300 + 32'(c * 4);
            settle();
            check("thr_arready", s_miso.arready, (c < 4));
        end
        check("thr_rd_out", rd_out, 4);
        tick();
        s_mosi.arvalid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            m_miso.rvalid = 1'b1; m_miso.rdata = 32'(c); m_miso.rresp = 2'b00;
            tick();
        end
        m_miso.rvalid = 1'b0;
        repeat (3) tick();
        settle();
        check("thr_drain_out", rd_out, 0);
        check("thr_drain_rdy", s_miso.arready, 1);
        check("thr_drain_idle", idle, 1);

        // ---------------- W backpressure ----------------
        m_miso.wready = 1'b0;
        for (int i = 0; i < 5; i++) exp_q.push_back(wd[i]);
        idx = 0; n_w = 0;
        for (int c = 0; c < 14; c++) begin
            tick();
            if (c == 4) m_miso.wready = 1'b1;
            if (idx < 5) begin
                s_mosi.wvalid = 1'b1; s_mosi.wdata = wd[idx]; s_mosi.wstrb = 4'hf;
            end else begin
                s_mosi.wvalid = 1'b0;
            end
            settle();
            if (c < 4) check("bp_wready", s_miso.wready, (c < 2));
            if (m_mosi.wvalid && m_miso.wready) begin
                check("bp_order", m_mosi.wdata, pop_exp(exp_q));
                n_w++;
            end
            if (s_mosi.wvalid && s_miso.wready) idx++;
        end
        s_mosi.wvalid = 1'b0;
        check("bp_count", n_w, 5);

        // ---------------- reset with two R beats buffered ----------------
        m_miso.arready = 1'b1; s_mosi.rready = 1'b0;
        tick();
        s_mosi.arvalid = 1'b1; s_mosi.araddr = 32'h0000_0400;
        tick();
        s_mosi.araddr = 32'h0000_0404;
        tick();
        s_mosi.arvalid = 1'b0;
        m_miso.rvalid = 1'b1; m_miso.rdata = 32'h0000_AAAA; m_miso.rresp = 2'b00;
        tick();
        m_miso.rdata = 32'h0000_BBBB;
        tick();
        m_miso.rvalid = 1'b0;
        tick();
        settle();
        check("mid_s_rvalid", s_miso.rvalid, 1);
        check("mid_rdata_head", s_miso.rdata, 32'h0000_AAAA);
        check("mid_rd_out", rd_out, 2);
        check("mid_rready_full", m_mosi.rready, 0);
        reset = 1'b1;
        #1;
        check("mid_rst_rvalid", s_miso.rvalid, 0);
        check("mid_rst_counts", {wr_out, rd_out}, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_arready", s_miso.arready, 0);
        tick();
        reset = 1'b0;
        tick();
        settle();
        check("post_rst_arready", s_miso.arready, 1);
        check("post_rst_rvalid", s_miso.rvalid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
